// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issue controller and iterative MUL/DIV engine in front of the combinational ALU
// Optional feature macro: ALU_SEQ_EARLY_EXIT_EN (MUL stops iterating once the remaining multiplier is zero)
module alu_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [OP_W-1:0]  alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_lo,
  output logic [WIDTH-1:0] rsp_hi,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(6);
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(7);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ITER, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [OP_W-1:0]    alu_op_q, alu_op_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [WIDTH-1:0]   rsp_lo_q, rsp_lo_d;
  logic [WIDTH-1:0]   rsp_hi_q, rsp_hi_d;
  logic               dbz_q, dbz_d;
  // MUL: acc = running product, mcand = |a| shifted left, mplier = |b| shifted right.
  // DIV: acc = {remainder, dividend/quotient}, mcand[WIDTH-1:0] = |b|.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               req_is_long;
  logic               req_div_zero;
  logic               skip_iter;
  logic               op_is_mul;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] mul_acc_next;
  logic [WIDTH-1:0]   mplier_next;
  logic [WIDTH:0]     rem_ext;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] div_acc_next;
  logic               last_iter;
  logic               res_neg;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quo_signed, rem_signed;

  assign abs_a        = req_a[WIDTH-1] ? -req_a : req_a;
  assign abs_b        = req_b[WIDTH-1] ? -req_b : req_b;
  assign req_div_zero = (req_op == OP_DIV) && (req_b == '0);
  assign req_is_long  = (req_op == OP_MUL) || (req_op == OP_DIV);
  assign op_is_mul    = (alu_op_q == OP_MUL);

`ifdef ALU_SEQ_EARLY_EXIT_EN
  assign skip_iter = (req_op == OP_MUL) && (req_b == '0);
`else
  assign skip_iter = 1'b0;
`endif

  // One shift-add step and one restoring-divide step, selected by the latched opcode
  always_comb begin
    mul_acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mplier_next  = mplier_q >> 1;
    rem_ext      = acc_q[2*WIDTH-1:WIDTH-1];
    rem_diff     = rem_ext - {1'b0, mcand_q[WIDTH-1:0]};
    if (rem_diff[WIDTH]) begin
      div_acc_next = {rem_ext[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_acc_next = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  // Iteration termination: fixed count, or remaining multiplier exhausted when enabled
  always_comb begin
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef ALU_SEQ_EARLY_EXIT_EN
    if (op_is_mul && (mplier_next == '0)) begin
      last_iter = 1'b1;
    end
`endif
  end

  // Sign restoration of the magnitude results
  always_comb begin
    res_neg     = alu_a_q[WIDTH-1] ^ alu_b_q[WIDTH-1];
    prod_signed = res_neg ? -acc_q : acc_q;
    quo_signed  = res_neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_signed  = alu_a_q[WIDTH-1] ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // State and datapath registers; clear abandons any op in flight
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= S_IDLE;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      rsp_lo_q <= '0;
      rsp_hi_q <= '0;
      dbz_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      rsp_lo_q <= rsp_lo_d;
      rsp_hi_q <= rsp_hi_d;
      dbz_q    <= dbz_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_div_zero || !req_is_long) state_d = S_ISSUE;
          else if (skip_iter)               state_d = S_FIX;
          else                              state_d = S_ITER;
        end
      end
      S_ISSUE: state_d = S_DONE;
      S_ITER:  if (last_iter) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: operand latch, iteration steps, result capture
  always_comb begin
    alu_op_d = alu_op_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    rsp_lo_d = rsp_lo_q;
    rsp_hi_d = rsp_hi_q;
    dbz_d    = dbz_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          alu_op_d = req_op;
          alu_a_d  = req_a;
          alu_b_d  = req_b;
          cnt_d    = '0;
          mplier_d = abs_b;
          if (req_op == OP_DIV) begin
            acc_d   = {{WIDTH{1'b0}}, abs_a};
            mcand_d = {{WIDTH{1'b0}}, abs_b};
          end else begin
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, abs_a};
          end
        end
      end
      S_ISSUE: begin
        // Only a zero-divisor DIV ever reaches ISSUE with the DIV opcode
        if (alu_op_q == OP_DIV) begin
          rsp_lo_d = '1;
          rsp_hi_d = alu_a_q;
          dbz_d    = 1'b1;
        end else begin
          rsp_lo_d = alu_result;
          rsp_hi_d = '0;
          dbz_d    = 1'b0;
        end
      end
      S_ITER: begin
        cnt_d = cnt_q + 1'b1;
        if (op_is_mul) begin
          acc_d    = mul_acc_next;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_next;
        end else begin
          acc_d = div_acc_next;
        end
      end
      S_FIX: begin
        dbz_d = 1'b0;
        if (op_is_mul) begin
          rsp_lo_d = prod_signed[WIDTH-1:0];
          rsp_hi_d = prod_signed[2*WIDTH-1:WIDTH];
        end else begin
          rsp_lo_d = quo_signed;
          rsp_hi_d = rem_signed;
        end
      end
      S_DONE: begin
        if (rsp_ready) dbz_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Outputs decoded from state plus registered values
  always_comb begin
    req_ready   = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    rsp_valid   = (state_q == S_DONE);
    alu_op      = alu_op_q;
    alu_a       = alu_a_q;
    alu_b       = alu_b_q;
    rsp_lo      = rsp_lo_q;
    rsp_hi      = rsp_hi_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_lo, rsp_hi;
  logic        div_by_zero, busy;

  int cmp_count  = 0;
  int fail_count = 0;

  always #5 clock = ~clock;

  alu_op_sequencer #(.WIDTH(32), .OP_W(4)) dut (
    .clock(clock), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lo(rsp_lo), .rsp_hi(rsp_hi),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  // Behavioural combinational ALU
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int s;
    s = int'(b[4:0]);
    case (op)
      4'd0:  return a | b;
      4'd1:  return a & b;
      4'd2:  return ~a;
      4'd3:  return a + b;
      4'd4:  return a - b;
      4'd5:  return -a;
      4'd8:  return a << s;
      4'd9:  return a >> s;
      4'd11: return (s == 0) ? a : ((a << s) | (a >> (32 - s)));
      4'd12: return (s == 0) ? a : ((a >> s) | (a << (32 - s)));
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result = alu_model(alu_op, alu_a, alu_b);

  // Reference: signed 64-bit arithmetic and latency rules
  task automatic ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] elo, output logic [31:0] ehi,
                           output logic edbz, output int elat);
    longint sa, sb, p, q, r, mb;
    int n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    edbz = 1'b0;
    if (op == 4'd6) begin
      p = sa * sb;
      elo = p[31:0];
      ehi = p[63:32];
`ifdef ALU_SEQ_EARLY_EXIT_EN
      mb = (sb < 0) ? -sb : sb;
      n = 0;
      while (mb != 0) begin n++; mb = mb >> 1; end
      elat = n + 2;
`else
      mb = 0;
      n = 0;
      elat = 34;
`endif
    end else if (op == 4'd7) begin
      if (b == 32'd0) begin
        elo = 32'hFFFF_FFFF; ehi = a; edbz = 1'b1; elat = 2;
      end else begin
        q = sa / sb;
        r = sa % sb;
        elo = q[31:0]; ehi = r[31:0]; elat = 34;
      end
    end else begin
      elo = alu_model(op, a, b); ehi = 32'd0; elat = 2;
    end
  endtask

  // Present one request and wait (bounded) for rsp_valid
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] lo, output logic [31:0] hi, output logic dbz, output int lat);
    @(negedge clock);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 100) begin
      @(posedge clock); #1; lat++;
    end
    lo = rsp_lo; hi = rsp_hi; dbz = div_by_zero;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
  endtask

  // Full op with every observable checked against the reference
  task automatic run_checked(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] lo, hi, elo, ehi;
    logic dbz, edbz;
    int lat, elat;
    ref_model(op, a, b, elo, ehi, edbz, elat);
    issue(op, a, b, lo, hi, dbz, lat);
    cmp_count++; if (lat != elat) begin fail_count++; $display("FAIL %s_lat op=%0d a=%h b=%h: got %0d want %0d", nm, op, a, b, lat, elat); end
    cmp_count++; if (lo !== elo) begin fail_count++; $display("FAIL %s_lo op=%0d a=%h b=%h: got %h want %h", nm, op, a, b, lo, elo); end
    cmp_count++; if (hi !== ehi) begin fail_count++; $display("FAIL %s_hi op=%0d a=%h b=%h: got %h want %h", nm, op, a, b, hi, ehi); end
    cmp_count++; if (dbz !== edbz) begin fail_count++; $display("FAIL %s_dbz op=%0d a=%h b=%h: got %b want %b", nm, op, a, b, dbz, edbz); end
    release_rsp();
  endtask

  task automatic test_reset();
    clear = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clock);
    #1;
    cmp_count++; if (req_ready !== 1'b1) begin fail_count++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    cmp_count++; if (busy !== 1'b0) begin fail_count++; $display("FAIL reset_busy: got %b want 0", busy); end
    cmp_count++; if (rsp_valid !== 1'b0) begin fail_count++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    cmp_count++; if ({rsp_lo, rsp_hi} !== 64'd0) begin fail_count++; $display("FAIL reset_rsp: got %h %h want 0", rsp_hi, rsp_lo); end
    cmp_count++; if ({alu_op, alu_a, alu_b, div_by_zero} !== 69'd0) begin fail_count++; $display("FAIL reset_alu: got %h %h %h %b want 0", alu_op, alu_a, alu_b, div_by_zero); end
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic test_single_cycle();
    run_checked("or", 4'd0, 32'd20, 32'd5);
    run_checked("add", 4'd3, 32'd20, 32'd5);
    for (int i = 0; i < 12; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op == 4'd6 || op == 4'd7) op = 4'd11;
      run_checked("single_rnd", op, $urandom, $urandom);
    end
  endtask

  task automatic test_mul();
    run_checked("mul_dir", 4'd6, 32'(-20), 32'd5);
    run_checked("mul_zero", 4'd6, 32'd12345, 32'd0);
    run_checked("mul_neg_b", 4'd6, 32'd7, 32'h8000_0000);
    for (int i = 0; i < 8; i++) begin
      run_checked("mul_rnd", 4'd6, $urandom, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 300)) : $urandom);
    end
  endtask

  task automatic test_div();
    run_checked("div_pn", 4'd7, 32'd20, 32'(-3));
    run_checked("div_np", 4'd7, 32'(-20), 32'd3);
    run_checked("div_ovf", 4'd7, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) begin
      run_checked("div_rnd", 4'd7, $urandom, ($urandom_range(0, 1) == 1) ? 32'(int'($urandom_range(1, 50)) - 25) : $urandom);
    end
  endtask

  task automatic test_div_by_zero();
    run_checked("dbz", 4'd7, 32'd20, 32'd0);
    cmp_count++; if (div_by_zero !== 1'b0) begin fail_count++; $display("FAIL dbz_drop: got %b want 0", div_by_zero); end
    run_checked("dbz_next", 4'd3, 32'd20, 32'd5);
  endtask

  task automatic test_backpressure();
    logic [31:0] lo, hi;
    logic dbz;
    int lat;
    issue(4'd4, 32'd100, 32'd30, lo, hi, dbz, lat);
    cmp_count++; if (lo !== 32'd70) begin fail_count++; $display("FAIL bp_lo: got %h want %h", lo, 32'd70); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      cmp_count++;
      if (rsp_valid !== 1'b1 || rsp_lo !== 32'd70 || rsp_hi !== 32'd0 || req_ready !== 1'b0) begin
        fail_count++;
        $display("FAIL bp_hold cyc %0d: got valid=%b lo=%h hi=%h ready=%b want 1/70/0/0", i, rsp_valid, rsp_lo, rsp_hi, req_ready);
      end
    end
    release_rsp();
    cmp_count++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fail_count++; $display("FAIL bp_release: got ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
    cmp_count++; if (rsp_lo !== 32'd70) begin fail_count++; $display("FAIL bp_lo_kept: got %h want %h", rsp_lo, 32'd70); end
  endtask

  task automatic test_clear_midflight();
    @(negedge clock);
    req_op = 4'd7; req_a = 32'd1000; req_b = 32'd7; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    cmp_count++; if (busy !== 1'b1) begin fail_count++; $display("FAIL clr_busy_before: got %b want 1", busy); end
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    cmp_count++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fail_count++; $display("FAIL clr_state: got busy=%b valid=%b ready=%b want 0/0/1", busy, rsp_valid, req_ready);
    end
    cmp_count++; if (rsp_lo !== 32'd0 || alu_op !== 4'd0) begin fail_count++; $display("FAIL clr_outputs: got lo=%h op=%h want 0/0", rsp_lo, alu_op); end
    run_checked("clr_after", 4'd3, 32'd20, 32'd5);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 25; i++) begin
      logic [3:0] op;
      logic [31:0] b;
      int sel;
      sel = int'($urandom_range(0, 3));
      op  = (sel == 0) ? 4'($urandom_range(0, 15)) : ((sel == 1) ? 4'd6 : 4'd7);
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(0, 64));
        2: b = 32'(-int'($urandom_range(1, 64)));
        default: b = $urandom;
      endcase
      run_checked("b2b", op, $urandom, b);
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mul();
    test_div();
    test_div_by_zero();
    test_backpressure();
    test_clear_midflight();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
